// File: rtl/fir_cmd_seq_pkg.sv
// Shared encodings for the FIR command sequencer: serial-filter command codes
// and the sequencer state enumeration.
package fir_cmd_seq_pkg;

    typedef enum logic [1:0] {
        CMD_MULT0 = 2'd0,
        CMD_MAC   = 2'd1,
        CMD_SHIFT = 2'd2,
        CMD_SEND  = 2'd3
    } cmd_t;

    typedef enum logic [2:0] {
        IDLE,
        MULT0,
        MAC,
        SHIFT,
        SEND
    } state_t;

    localparam int DATA_W  = 32;
    localparam int SHIFT_W = 7;

    // Command issued while the sequencer sits in a given state; IDLE maps to 0
    // so the command bus rests at zero between bursts.
    function automatic cmd_t state_cmd(input state_t s);
        case (s)
            MAC:     return CMD_MAC;
            SHIFT:   return CMD_SHIFT;
            SEND:    return CMD_SEND;
            default: return CMD_MULT0;
        endcase
    endfunction

endpackage

// File: rtl/fir_hist_ram.sv
// DEPTH x DW storage with one write port and one registered, write-first read
// port; contents and read register clear on rst.
module fir_hist_ram #(
    parameter int DEPTH = 8,
    parameter int AW    = 4,
    parameter int DW    = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rd_data
);

    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DW-1:0] mem [DEPTH];

    // A disabled read returns zero so the read register doubles as a gated operand.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            rd_data <= '0;
        end else begin
            if (we) begin
                mem[waddr[IW-1:0]] <= wdata;
            end
            if (!re) begin
                rd_data <= '0;
            end else if (we && (waddr == raddr)) begin
                rd_data <= wdata;
            end else begin
                rd_data <= mem[raddr[IW-1:0]];
            end
        end
    end

endmodule

// File: rtl/fir_cmd_seq.sv
// Turns each accepted sample into an NTAPS+2 command burst (mult, MACs,
// shift, send) for a serial FIR datapath, from circular history and coefficient banks.
import fir_cmd_seq_pkg::*;

module fir_cmd_seq #(
    parameter int NTAPS = 8,
    parameter int AW    = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              coef_we,
    input  logic [AW-1:0]     coef_addr,
    input  logic [31:0]       coef_data,
    output logic              coef_ready,
    input  logic [6:0]        shift_amt,
    input  logic              in_valid,
    input  logic [31:0]       in_sample,
    output logic              in_ready,
    output logic              pushout,
    output logic [1:0]        cmd,
    output logic [31:0]       q,
    output logic [31:0]       h
);

    localparam logic [AW-1:0] LAST_TAP = AW'(NTAPS - 1);

    state_t              state_reg, state_next;
    logic [AW-1:0]       wptr_reg, newest_reg, tap_reg, tap_next, tap_inc;
    logic [SHIFT_W-1:0]  shift_reg;
    logic                pushout_reg;
    cmd_t                cmd_reg;
    logic [DATA_W-1:0]   h_aux_reg;
    logic                accept, coef_wr, rd_en;
    logic [AW-1:0]       hist_raddr, coef_raddr;
    logic [AW:0]         back_sum;
    logic [DATA_W-1:0]   hist_rd, coef_rd;

    assign in_ready   = (state_reg == IDLE);
    assign coef_ready = (state_reg == IDLE);
    assign accept     = in_valid && in_ready;
    assign coef_wr    = coef_we && coef_ready && ({1'b0, coef_addr} < (AW+1)'(NTAPS));
    assign tap_inc    = tap_reg + AW'(1);

    // (newest - k) mod NTAPS without a divider: add NTAPS back when k overtakes newest.
    assign back_sum = {1'b0, newest_reg}
                    + ((tap_inc <= newest_reg) ? (AW+1)'(0) : (AW+1)'(NTAPS))
                    - {1'b0, tap_inc};

    always_comb begin
        state_next = state_reg;
        tap_next   = tap_reg;
        rd_en      = 1'b0;
        hist_raddr = '0;
        coef_raddr = '0;
        case (state_reg)
            IDLE: begin
                if (accept) begin
                    state_next = MULT0;
                    tap_next   = '0;
                    rd_en      = 1'b1;
                    hist_raddr = wptr_reg;
                end
            end
            MULT0, MAC: begin
                if (tap_reg == LAST_TAP) begin
                    state_next = SHIFT;
                end else begin
                    state_next = MAC;
                    tap_next   = tap_inc;
                    rd_en      = 1'b1;
                    hist_raddr = back_sum[AW-1:0];
                    coef_raddr = tap_inc;
                end
            end
            SHIFT:   state_next = SEND;
            SEND:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= IDLE;
            wptr_reg    <= '0;
            newest_reg  <= '0;
            tap_reg     <= '0;
            shift_reg   <= '0;
            pushout_reg <= 1'b0;
            cmd_reg     <= CMD_MULT0;
            h_aux_reg   <= '0;
        end else begin
            state_reg <= state_next;
            tap_reg   <= tap_next;
            if (accept) begin
                newest_reg <= wptr_reg;
                wptr_reg   <= (wptr_reg == LAST_TAP) ? '0 : wptr_reg + AW'(1);
                shift_reg  <= shift_amt;
            end
            pushout_reg <= (state_next != IDLE);
            cmd_reg     <= state_cmd(state_next);
            h_aux_reg   <= (state_next == SHIFT) ? {25'b0, shift_reg} : '0;
        end
    end

    fir_hist_ram #(.DEPTH(NTAPS), .AW(AW), .DW(DATA_W)) u_hist (
        .clk     (clk),
        .rst     (rst),
        .we      (accept),
        .waddr   (wptr_reg),
        .wdata   (in_sample),
        .re      (rd_en),
        .raddr   (hist_raddr),
        .rd_data (hist_rd)
    );

    fir_hist_ram #(.DEPTH(NTAPS), .AW(AW), .DW(DATA_W)) u_coef (
        .clk     (clk),
        .rst     (rst),
        .we      (coef_wr),
        .waddr   (coef_addr),
        .wdata   (coef_data),
        .re      (rd_en),
        .raddr   (coef_raddr),
        .rd_data (coef_rd)
    );

    // Both sources are registers and never non-zero together, so OR acts as the h mux.
    assign pushout = pushout_reg;
    assign cmd     = cmd_reg;
    assign q       = hist_rd;
    assign h       = coef_rd | h_aux_reg;

endmodule
